// File: rtl/axi_burst_coalescer_if.sv
// axi_burst_coalescer_if: beat-address stream in, AXI4 AW channel out.
// slave = coalescer view, master = beat producer / AW sink view.
interface axi_burst_coalescer_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] i_beat_addr;
  logic                  i_beat_valid;
  logic                  i_beat_ready;
  logic                  i_flush;
  logic [ADDR_WIDTH-1:0] o_awaddr;
  logic [7:0]            o_awlen;
  logic [2:0]            o_awsize;
  logic [1:0]            o_awburst;
  logic                  o_awvalid;
  logic                  o_awready;

  modport slave (
    input  i_beat_addr,
    input  i_beat_valid,
    input  i_flush,
    input  o_awready,
    output i_beat_ready,
    output o_awaddr,
    output o_awlen,
    output o_awsize,
    output o_awburst,
    output o_awvalid
  );

  modport master (
    output i_beat_addr,
    output i_beat_valid,
    output i_flush,
    output o_awready,
    input  i_beat_ready,
    input  o_awaddr,
    input  o_awlen,
    input  o_awsize,
    input  o_awburst,
    input  o_awvalid
  );
endinterface

// File: rtl/axi_burst_coalescer.sv
// axi_burst_coalescer: merges contiguous per-beat write addresses into
// AXI4 INCR AW bursts (one awaddr/awlen per contiguous run).
// Ports: clk, reset (async, active-high); bus (axi_burst_coalescer_if.slave):
//   i_beat_addr/i_beat_valid/i_beat_ready beat stream, i_flush closes the run,
//   o_awaddr/o_awlen/o_awsize/o_awburst/o_awvalid/o_awready AW channel.
// Option: define AXI_BURST_COALESCER_TIMEOUT_EN to auto-close an open run
//   after IDLE_TIMEOUT cycles without an accepted beat.
module axi_burst_coalescer #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_LEN      = 16,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  axi_burst_coalescer_if.slave   bus
);

  localparam int AW   = ADDR_WIDTH;
  localparam int INCR = DATA_WIDTH / 8;
  localparam int SZ   = $clog2(INCR);

  localparam logic [AW-1:0] LO_MASK = AW'(INCR - 1);
  localparam logic [AW-1:0] TOP     = ~LO_MASK;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_ISSUE
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;

  logic [AW-1:0]   r_start;
  logic [8:0]      r_count;
  logic            r_pend;
  logic [AW-1:0]   r_pend_addr;
  logic [AW-1:0]   r_awaddr;
  logic [7:0]      r_awlen;

  logic [AW-1:0]   w_addr;
  logic [AW:0]     w_next;
  logic [8:0]      w_cnt_inc;
  logic            w_acc;
  logic            w_contig;
  logic            w_full_inc;
  logic            w_top_inc;
  logic            w_hold_close;
  logic            w_timeout;
  logic            w_merge;
  logic            w_pend_ld;
  logic            w_close_ld;
  logic [8:0]      w_len_cnt;

  assign w_addr    = bus.i_beat_addr & ~LO_MASK;

  // One bit wider than the address: a set MSB means the run already
  // ends at the top of the page and cannot grow.
  assign w_next    = {1'b0, r_start} + ((AW+1)'(r_count) << SZ);

  assign w_cnt_inc = r_count + 9'd1;

  assign w_contig  = (w_addr == w_next[AW-1:0]) && !w_next[AW];

  assign w_full_inc = (w_cnt_inc >= 9'(MAX_LEN));

  assign w_top_inc  = (w_addr == TOP);

  // Covers a run reopened from the pending beat (or opened in IDLE) that
  // is already full or already sits on the last aligned address.
  assign w_hold_close = (r_count >= 9'(MAX_LEN)) || w_next[AW];

  assign bus.i_beat_ready = (r_state != S_ISSUE);

  assign w_acc = bus.i_beat_valid && bus.i_beat_ready;

`ifdef AXI_BURST_COALESCER_TIMEOUT_EN
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  logic [TW-1:0] r_timer;

  // An accepted beat in the expiry cycle wins over the timeout.
  assign w_timeout = (r_state == S_ACCUM) && !w_acc &&
                     (r_timer == TW'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (r_state == S_ACCUM &&
                 w_state_nx == S_ACCUM && !w_acc) begin
      r_timer <= r_timer + TW'(1);
    end else begin
      r_timer <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_merge    = 1'b0;
    w_pend_ld  = 1'b0;
    w_close_ld = 1'b0;
    w_len_cnt  = r_count;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_state_nx = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_acc && w_contig) begin
          w_merge   = 1'b1;
          w_len_cnt = w_cnt_inc;
          if (w_full_inc || w_top_inc || bus.i_flush) begin
            w_close_ld = 1'b1;
          end
        end else if (w_acc) begin
          w_pend_ld  = 1'b1;
          w_close_ld = 1'b1;
        end else if (bus.i_flush || w_hold_close || w_timeout) begin
          w_close_ld = 1'b1;
        end
        if (w_close_ld) begin
          w_state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.o_awready) begin
          w_state_nx = r_pend ? S_ACCUM : S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start     <= '0;
      r_count     <= '0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_awaddr    <= '0;
      r_awlen     <= '0;
    end else begin
      if (r_state == S_IDLE && w_acc) begin
        r_start <= w_addr;
        r_count <= 9'd1;
      end
      if (w_merge) begin
        r_count <= w_cnt_inc;
      end
      if (w_pend_ld) begin
        r_pend      <= 1'b1;
        r_pend_addr <= w_addr;
      end
      // AW fields are frozen here and held until the handshake.
      if (w_close_ld) begin
        r_awaddr <= r_start;
        r_awlen  <= 8'(w_len_cnt - 9'd1);
      end
      if (r_state == S_ISSUE && bus.o_awready) begin
        if (r_pend) begin
          r_start <= r_pend_addr;
          r_count <= 9'd1;
          r_pend  <= 1'b0;
        end else begin
          r_count <= '0;
        end
      end
    end
  end

  assign bus.o_awvalid = (r_state == S_ISSUE);
  assign bus.o_awaddr  = r_awaddr;
  assign bus.o_awlen   = r_awlen;
  assign bus.o_awsize  = 3'(SZ);
  assign bus.o_awburst = 2'b01;

endmodule

// File: tb/tb_axi_burst_coalescer.sv
// tb_axi_burst_coalescer: directed literal cases plus randomized traffic
// checked every cycle against a run-level model of the coalescer.
module tb_axi_burst_coalescer;

  localparam int MAXL = 16;
  localparam int TOUT = 8;
`ifdef AXI_BURST_COALESCER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  axi_burst_coalescer_if #(.ADDR_WIDTH(12)) bus ();

  axi_burst_coalescer #(
    .ADDR_WIDTH  (12),
    .DATA_WIDTH  (32),
    .MAX_LEN     (MAXL),
    .IDLE_TIMEOUT(TOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int q_addr[$];
  int q_len[$];
  int e_addr[$];
  int e_len[$];

  // run-level model
  int m_start, m_n, m_pa, m_idle, m_aw_addr, m_aw_len;
  bit m_pv, m_aw_on;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_start = 0; m_n = 0; m_pa = 0; m_idle = 0;
    m_aw_addr = 0; m_aw_len = 0; m_pv = 0; m_aw_on = 0;
  endtask

  // Applies the inputs that the coming rising edge will sample.
  task automatic m_step();
    int a;
    int nx;
    bit close;
    a = int'(bus.i_beat_addr) & 'hFFC;
    if (m_aw_on) begin
      if (bus.o_awready) begin
        m_aw_on = 0;
        if (m_pv) begin
          m_start = m_pa; m_n = 1; m_pv = 0; m_idle = 0;
        end
      end
    end else begin
      close = 0;
      nx = m_start + m_n * 4;
      if (bus.i_beat_valid) begin
        if (m_n == 0) begin
          m_start = a; m_n = 1; m_idle = 0;
        end else begin
          m_idle = 0;
          if (a == nx && nx < 4096) begin
            m_n++;
            close = (m_n == MAXL) || (a + 4 == 4096) || bus.i_flush;
          end else begin
            m_pv = 1; m_pa = a; close = 1;
          end
        end
      end else if (m_n > 0) begin
        m_idle++;
        close = bus.i_flush || m_n >= MAXL || nx >= 4096 ||
                (TO_EN && m_idle >= TOUT);
      end
      if (close) begin
        m_aw_on = 1; m_aw_addr = m_start; m_aw_len = m_n - 1;
        m_n = 0; m_idle = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      m_reset();
      chk("rst_awvalid", int'(bus.o_awvalid), 0);
      chk("rst_awaddr", int'(bus.o_awaddr), 0);
      chk("rst_awlen", int'(bus.o_awlen), 0);
    end else begin
      chk("awvalid", int'(bus.o_awvalid), int'(m_aw_on));
      chk("beat_ready", int'(bus.i_beat_ready), int'(!m_aw_on));
      if (m_aw_on) begin
        chk("awaddr", int'(bus.o_awaddr), m_aw_addr);
        chk("awlen", int'(bus.o_awlen), m_aw_len);
        chk("awsize", int'(bus.o_awsize), 2);
        chk("awburst", int'(bus.o_awburst), 1);
      end
      if (bus.o_awvalid && bus.o_awready) begin
        q_addr.push_back(int'(bus.o_awaddr));
        q_len.push_back(int'(bus.o_awlen));
      end
      m_step();
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input int a);
    int k;
    bus.i_beat_addr  = 12'(a);
    bus.i_beat_valid = 1'b1;
    k = 0;
    while (!bus.i_beat_ready && k < 100) begin
      k++;
      idle(1);
    end
    if (k >= 100) begin
      chk("beat_accept_wait", 0, 1);
    end
    idle(1);
    bus.i_beat_valid = 1'b0;
  endtask

  task automatic flush();
    int k;
    k = 0;
    while (!bus.i_beat_ready && k < 100) begin
      k++;
      idle(1);
    end
    if (k >= 100) begin
      chk("flush_wait", 0, 1);
    end
    bus.i_flush = 1'b1;
    idle(1);
    bus.i_flush = 1'b0;
  endtask

  task automatic exp_aw(input int a, input int l);
    e_addr.push_back(a);
    e_len.push_back(l);
  endtask

  task automatic check_aw(input string nm);
    chk({nm, "_count"}, q_addr.size(), e_addr.size());
    for (int i = 0; i < e_addr.size() && i < q_addr.size(); i++) begin
      chk({nm, "_addr"}, q_addr[i], e_addr[i]);
      chk({nm, "_len"}, q_len[i], e_len[i]);
    end
    q_addr.delete(); q_len.delete();
    e_addr.delete(); e_len.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int r;
    reset = 1'b1;
    bus.i_beat_addr  = '0;
    bus.i_beat_valid = 1'b0;
    bus.i_flush      = 1'b0;
    bus.o_awready    = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    chk("ready_after_reset", int'(bus.i_beat_ready), 1);

    // 1: four contiguous beats then flush
    beat('h100); beat('h104); beat('h108); beat('h10C);
    flush(); idle(4);
    exp_aw('h100, 3);
    check_aw("t1");

    // 2: 20 contiguous beats split at MAX_LEN
    for (int i = 0; i < 20; i++) beat(i * 4);
    flush(); idle(4);
    exp_aw('h000, 15); exp_aw('h040, 3);
    check_aw("t2");

    // 3: discontinuity pends the third beat
    beat('h200); beat('h204); beat('h300);
    flush(); idle(4);
    exp_aw('h200, 1); exp_aw('h300, 0);
    check_aw("t3");

    // 4: top-of-page closes without flush; low bits ignored
    beat('hFF8); beat('hFFF); idle(4);
    exp_aw('hFF8, 1);
    check_aw("t4a");
    beat('h000); flush(); idle(4);
    exp_aw('h000, 0);
    check_aw("t4b");

    // 5: AW held under backpressure
    bus.o_awready = 1'b0;
    beat('h500); beat('h504); flush();
    repeat (5) begin
      @(negedge clk);
      chk("t5_awvalid", int'(bus.o_awvalid), 1);
      chk("t5_ready", int'(bus.i_beat_ready), 0);
      chk("t5_awaddr", int'(bus.o_awaddr), 'h500);
      chk("t5_awlen", int'(bus.o_awlen), 1);
    end
    idle(1);
    bus.o_awready = 1'b1;
    idle(4);
    exp_aw('h500, 1);
    check_aw("t5");

    // 6: idle open run; only the timeout build closes it
    beat('h040); beat('h044); idle(12);
    if (TO_EN) exp_aw('h040, 1);
    check_aw("t6a");
    flush(); idle(4);
    if (!TO_EN) exp_aw('h040, 1);
    check_aw("t6b");

    // 7: reset while issuing with a pending beat
    bus.o_awready = 1'b0;
    beat('h600); beat('h604); beat('h700);
    idle(2);
    reset = 1'b1;
    #1;
    chk("t7_awvalid_async", int'(bus.o_awvalid), 0);
    chk("t7_awaddr_async", int'(bus.o_awaddr), 0);
    idle(2);
    reset = 1'b0;
    bus.o_awready = 1'b1;
    idle(10);
    check_aw("t7");

    // 8: reset mid-accumulation
    beat('h800); beat('h804);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2);
    flush(); idle(4);
    check_aw("t8");

    // randomized traffic
    last = 0;
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)      last = (last + 4) & 'hFFC;
      else if (r < 8) last = int'($urandom_range(0, 4095)) & 'hFFC;
      else if (r < 9) last = 'hFF0 + int'($urandom_range(0, 3)) * 4;
      bus.i_beat_addr  = 12'(last + int'($urandom_range(0, 3)));
      bus.i_beat_valid = ($urandom_range(0, 99) < 60);
      bus.i_flush      = ($urandom_range(0, 99) < 6);
      bus.o_awready    = ($urandom_range(0, 99) < 65);
      idle(1);
    end
    bus.i_beat_valid = 1'b0;
    bus.i_flush      = 1'b0;
    bus.o_awready    = 1'b1;
    idle(3);
    flush(); idle(20);
    chk("drain_awvalid", int'(bus.o_awvalid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
